eu_arith_mc: RTL and testbench

Multi-cycle, parametrised arithmetic execution unit for the datapath. It accepts one micro-operation per request under a start/done handshake and registers the result and a full status-flag set (Z, C, N, V). It adds add-with-carry and an iterative shift-add multiply to the existing MOVA/INC/ADD/SUB/DEC set. It sits alongside the logic/shift execution units and is selected when `op_select[3]==0`.

---
 rtl/eu_pkg.sv | 27 ++
 rtl/eu_mul_shift_add.sv | 66 ++++++
 rtl/eu_arith_mc.sv | 149 ++++++++++++++
 tb/tb_eu_arith_mc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/eu_pkg.sv
// Shared opcodes, FSM state encoding and status-flag layout for the arithmetic
// execution unit and its multiplier.
package eu_pkg;

   localparam logic [2:0] OP_MOVA = 3'b000;
   localparam logic [2:0] OP_INC  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ADC  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_DEC  = 3'b110;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_MUL  = 2'd2;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } flags_t;

   localparam flags_t FLAGS_RST = '{z: 1'b1, c: 1'b0, n: 1'b0, v: 1'b0};

endpackage

// File: rtl/eu_mul_shift_add.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// The last iteration is presented combinationally so the caller can latch it with done.
module eu_mul_shift_add #(
   parameter int BUS_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [BUS_WIDTH-1:0]     a,
   input  logic [BUS_WIDTH-1:0]     b,
   output logic                     done,
   output logic [2*BUS_WIDTH-1:0]   product
);

   localparam int PW = 2 * BUS_WIDTH;
   localparam int CW = $clog2(BUS_WIDTH) + 1;

   logic                 run_q, run_d;
   logic [PW-1:0]        acc_q, acc_d;
   logic [PW-1:0]        mcand_q, mcand_d;
   logic [BUS_WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        acc_nxt;

   always_comb begin
      acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
      done     = run_q && (cnt_q == CW'(BUS_WIDTH - 1));
      product  = acc_nxt;
      run_d    = run_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      // Bit 0 is consumed at load so BUS_WIDTH bits finish in BUS_WIDTH-1 more edges.
      if (start) begin
         run_d    = 1'b1;
         acc_d    = b[0] ? {{BUS_WIDTH{1'b0}}, a} : '0;
         mcand_d  = {{(BUS_WIDTH-1){1'b0}}, a, 1'b0};
         mplier_d = {1'b0, b[BUS_WIDTH-1:1]};
         cnt_d    = CW'(1);
      end else if (run_q) begin
         acc_d    = acc_nxt;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (done) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         run_q    <= run_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/eu_arith_mc.sv
// Multi-cycle arithmetic execution unit: MOVA/INC/ADD/ADC/SUB/DEC in one cycle,
// MUL via the shift-add sub-module, with registered result and Z/C/N/V flags.
module eu_arith_mc
   import eu_pkg::*;
#(
   parameter int BUS_WIDTH = 16,
   parameter bit MUL_EN    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           op_select,
   input  logic [BUS_WIDTH-1:0] A,
   input  logic [BUS_WIDTH-1:0] B,
   output logic                 busy,
   output logic                 done,
   output logic [BUS_WIDTH-1:0] data_out,
   output logic                 zero,
   output logic                 carry,
   output logic                 negative,
   output logic                 overflow,
   output logic                 illegal
);

   localparam int W1  = BUS_WIDTH + 1;
   localparam int MSB = BUS_WIDTH - 1;

   state_t               state_q, state_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   flags_t               flags_q, flags_d;
   logic                 illegal_q, illegal_d;

   logic                 mul_start, mul_done;
   logic [2*BUS_WIDTH-1:0] mul_prod;

   logic [BUS_WIDTH:0]   ea, sum;
   logic                 alu_v, op_bad;
   flags_t               alu_flags, mul_flags;

   // Single-cycle results are computed straight from the accepted operands.
   always_comb begin
      ea    = {1'b0, A};
      sum   = ea;
      alu_v = 1'b0;
      case (op_select[2:0])
         OP_INC: begin
            sum   = ea + W1'(1);
            alu_v = ~A[MSB] & sum[MSB];
         end
         OP_ADD: begin
            sum   = ea + {1'b0, B};
            alu_v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OP_ADC: begin
            sum   = ea + {1'b0, B} + W1'(flags_q.c);
            alu_v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OP_SUB: begin
            sum   = ea + {1'b0, ~B} + W1'(1);
            alu_v = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OP_DEC: begin
            sum   = ea + {1'b0, {BUS_WIDTH{1'b1}}};
            alu_v = A[MSB] & ~sum[MSB];
         end
         default: sum = ea;
      endcase
      alu_flags = '{z: (sum[MSB:0] == '0), c: sum[BUS_WIDTH], n: sum[MSB], v: alu_v};
      mul_flags = '{z: (mul_prod[MSB:0] == '0), c: |mul_prod[2*BUS_WIDTH-1:BUS_WIDTH],
                    n: mul_prod[MSB], v: 1'b0};
      op_bad    = op_select[3] || (op_select[2:0] == 3'b111) ||
                  (!MUL_EN && (op_select[2:0] == OP_MUL));
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      flags_d   = flags_q;
      illegal_d = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op_bad) begin
                  illegal_d = 1'b1;
               end else if (op_select[2:0] == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_MUL;
               end else begin
                  data_d  = sum[MSB:0];
                  flags_d = alu_flags;
                  state_d = ST_EXEC;
               end
            end
         end
         // EXEC is the done cycle for both paths.
         ST_MUL: begin
            if (mul_done) begin
               data_d  = mul_prod[MSB:0];
               flags_d = mul_flags;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         flags_q   <= FLAGS_RST;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
      end
   end

   generate
      if (MUL_EN) begin : g_mul
         eu_mul_shift_add #(.BUS_WIDTH(BUS_WIDTH)) u_mul (
            .clk     (clk),
            .rst     (rst),
            .start   (mul_start),
            .a       (A),
            .b       (B),
            .done    (mul_done),
            .product (mul_prod)
         );
      end else begin : g_no_mul
         assign mul_done = 1'b0;
         assign mul_prod = '0;
      end
   endgenerate

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_EXEC);
   assign data_out = data_q;
   assign zero     = flags_q.z;
   assign carry    = flags_q.c;
   assign negative = flags_q.n;
   assign overflow = flags_q.v;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_eu_arith_mc.sv
// Randomized self-checking bench for eu_arith_mc against an arithmetic reference model.
module tb_eu_arith_mc;

   localparam int     W = 16;
   localparam longint M = 64'sd1 <<< W;
   localparam longint H = M / 2;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [3:0]   op_select;
   logic [W-1:0] A, B;
   logic         busy, done, zero, carry, negative, overflow, illegal;
   logic [W-1:0] data_out;

   int n_chk = 0;
   int n_err = 0;

   longint m_data;
   bit     m_z, m_c, m_n, m_v;

   always #5 clk = ~clk;

   eu_arith_mc #(.BUS_WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .op_select(op_select), .A(A), .B(B),
      .busy(busy), .done(done), .data_out(data_out), .zero(zero), .carry(carry),
      .negative(negative), .overflow(overflow), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sgn(input longint x);
      return (x >= H) ? x - M : x;
   endfunction

   function automatic longint pick_operand();
      case ($urandom_range(0, 5))
         0:       return 0;
         1:       return M - 1;
         2:       return H - 1;
         3:       return H;
         default: return longint'($urandom_range(0, 32'(M - 1)));
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input longint a, input longint b, input string tag);
      bit     legal, c, v, seen;
      int     lat, k;
      longint full, sr, r;
      legal = (op <= 4'd6);
      lat   = (op == 4'd4) ? W : 1;
      c = 0; v = 0; r = m_data; full = 0; sr = 0;
      case (op)
         4'd0: begin r = a; end
         4'd1: begin full = a + 1;        sr = sgn(a) + 1; end
         4'd2: begin full = a + b;        sr = sgn(a) + sgn(b); end
         4'd3: begin full = a + b + m_c;  sr = sgn(a) + sgn(b) + m_c; end
         4'd4: begin full = a * b; end
         4'd5: begin full = a - b;        sr = sgn(a) - sgn(b); end
         4'd6: begin full = a - 1;        sr = sgn(a) - 1; end
         default: ;
      endcase
      if (op inside {4'd1, 4'd2, 4'd3}) begin
         r = full % M; c = (full >= M); v = (sr < -H) || (sr >= H);
      end else if (op inside {4'd5, 4'd6}) begin
         r = (full + M) % M; c = (full >= 0); v = (sr < -H) || (sr >= H);
      end else if (op == 4'd4) begin
         r = full % M; c = ((full / M) != 0);
      end

      @(negedge clk);
      start = 1'b1; op_select = op; A = W'(a); B = W'(b);
      @(posedge clk);
      #1;
      start = 1'b0; op_select = 4'($urandom); A = W'($urandom); B = W'($urandom);
      k = 0; seen = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (done || illegal) seen = 1;
         else begin
            if (op == 4'd4 && k == 2) chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
            if (op == 4'd4 && k == 3) begin
               start = 1'b1; op_select = 4'd2; A = W'($urandom); B = W'($urandom);
            end else start = 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, 64'(k), 64'(lat));
      if (legal) begin
         chk({tag, "_done"}, 64'({done, busy, illegal}), 64'(3'b110));
         m_data = r; m_z = (r == 0); m_c = c; m_n = r[W-1]; m_v = v;
      end else begin
         chk({tag, "_illegal"}, 64'({done, busy, illegal}), 64'(3'b001));
      end
      chk({tag, "_data"}, 64'(data_out), 64'(m_data));
      chk({tag, "_flags"}, 64'({zero, carry, negative, overflow}), 64'({m_z, m_c, m_n, m_v}));
      if (!legal) begin
         @(negedge clk);
         chk({tag, "_ill_pulse"}, 64'({done, illegal}), 64'd0);
      end
   endtask

   initial begin
      bit     seen;
      logic [3:0] op;
      rst = 1'b1; start = 1'b0; op_select = 4'd0; A = '0; B = '0;
      m_data = 0; m_z = 1; m_c = 0; m_n = 0; m_v = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_data", 64'(data_out), 64'd0);
      chk("reset_ctl", 64'({busy, done, illegal}), 64'd0);
      chk("reset_flags", 64'({zero, carry, negative, overflow}), 64'(4'b1000));

      run_op(4'd2, 64'h7FFF, 64'h0001, "add_ovf");
      chk("add_ovf_const", 64'({data_out, zero, carry, negative, overflow}), 64'({16'h8000, 4'b0011}));
      run_op(4'd5, 64'h0003, 64'h0003, "sub_eq");
      chk("sub_eq_const", 64'({data_out, zero, carry}), 64'({16'h0000, 2'b11}));
      run_op(4'd6, 64'h0000, 64'h0000, "dec_zero");
      chk("dec_zero_const", 64'({data_out, carry, negative}), 64'({16'hFFFF, 2'b01}));
      run_op(4'd2, 64'hFFFF, 64'h0001, "add_carry");
      run_op(4'd3, 64'h0001, 64'h0001, "adc");
      chk("adc_const", 64'(data_out), 64'h0003);
      run_op(4'd4, 64'h0012, 64'h0034, "mul");
      chk("mul_const", 64'({data_out, carry}), 64'({16'h03A8, 1'b0}));
      run_op(4'd4, 64'hFFFF, 64'hFFFF, "mul_hi");
      run_op(4'b1000, 64'h1234, 64'h5678, "ill_b3");
      run_op(4'b0111, 64'h1234, 64'h5678, "ill_111");

      for (int i = 0; i < 60; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
         run_op(op, pick_operand(), pick_operand(), "rand");
      end

      @(negedge clk);
      start = 1'b1; op_select = 4'd4; A = 16'h0012; B = 16'h0034;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ctl", 64'({busy, done, illegal}), 64'd0);
      chk("abort_data", 64'({data_out, zero, carry, negative, overflow}), 64'({16'h0000, 4'b1000}));
      rst = 1'b0;
      m_data = 0; m_z = 1; m_c = 0; m_n = 0; m_v = 0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      run_op(4'd1, 64'h00FF, 64'h0000, "inc_after_rst");
      chk("inc_after_rst_const", 64'(data_out), 64'h0100);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
